// File: rtl/reg_op_pkg.sv
// reg_op_pkg: opcodes, FSM state encoding and flag bit positions shared by the sequencer and its ALU.
package reg_op_pkg;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_ORR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_MOV = 3'd5, OP_CMP = 3'd6, OP_CLR = 3'd7;
  localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_EXEC = 2'd2, S_WRITE = 2'd3;
  localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
endpackage

// File: rtl/reg_op_alu.sv
// reg_op_alu: combinational ALU producing the result and {N,Z,C,V}; logic ops keep the incoming C/V.
module reg_op_alu
  import reg_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  logic [WIDTH:0] sum, diff;
  logic c, v;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    result = '0;
    c = c_in;
    v = v_in;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        result = diff[WIDTH-1:0];
        c = ~diff[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_ORR: result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = b;
      default: result = '0;
    endcase
  end
  assign flags = {result[WIDTH-1], result == '0, c, v};
endmodule

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: IDLE/READ/EXEC/WRITE controller running one register-file ALU op per four cycles.
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [3:0]       rd_addr,
  input  logic [3:0]       rs1_addr,
  input  logic [3:0]       rs2_addr,
  input  logic [WIDTH-1:0] rf_rd1,
  input  logic [WIDTH-1:0] rf_rd2,
  output logic [3:0]       src1_addr,
  output logic [3:0]       src2_addr,
  output logic [3:0]       dest_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_en,
  output logic             done,
  output logic [3:0]       flags
);
  logic [1:0] state;
  logic [2:0] op_q;
  logic [3:0] rd_q, rs1_q, rs2_q, new_flags, alu_flags;
  logic [WIDTH-1:0] a_q, b_q, alu_res;
  reg_op_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode(op_q),
    .a     (a_q),
    .b     (b_q),
    .c_in  (flags[FLAG_C]),
    .v_in  (flags[FLAG_V]),
    .result(alu_res),
    .flags (alu_flags)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      new_flags <= '0;
      dest_addr <= '0;
      wr_data   <= '0;
      flags     <= '0;
    end else begin
      case (state)
        S_IDLE: if (op_valid) begin
          op_q  <= opcode;
          rd_q  <= rd_addr;
          rs1_q <= rs1_addr;
          rs2_q <= rs2_addr;
          state <= S_READ;
        end
        S_READ: begin
          a_q   <= rf_rd1;
          b_q   <= rf_rd2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          wr_data   <= alu_res;
          dest_addr <= rd_q;
          new_flags <= alu_flags;
          state     <= S_WRITE;
        end
        default: begin
          flags <= new_flags;
          state <= S_IDLE;
        end
      endcase
    end
  end
  assign op_ready  = state == S_IDLE;
  assign src1_addr = state == S_READ ? rs1_q : '0;
  assign src2_addr = state == S_READ ? rs2_q : '0;
  assign done      = state == S_WRITE;
  assign wr_en     = done && op_q != OP_CMP;
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: drives the sequencer against a behavioural register file and ALU model.
module tb_reg_op_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0;
  logic op_ready, wr_en, done;
  logic [2:0] opcode = '0;
  logic [3:0] rd_addr = '0, rs1_addr = '0, rs2_addr = '0;
  logic [3:0] src1_addr, src2_addr, dest_addr, flags;
  logic [31:0] rf_rd1, rf_rd2, wr_data;
  logic ld_en = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] rf [16];
  logic [31:0] m [16];
  logic [3:0] mflags = '0;
  int compared = 0, mismatched = 0;

  reg_op_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .dest_addr(dest_addr), .wr_data(wr_data),
    .wr_en(wr_en), .done(done), .flags(flags)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT; ld_* lets the bench preload it when the DUT is not writing.
  assign rf_rd1 = rf[src1_addr];
  assign rf_rd2 = rf[src2_addr];
  always_ff @(posedge clk) begin
    if (wr_en) rf[dest_addr] <= wr_data;
    else if (ld_en) rf[ld_addr] <= ld_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] f_in, output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, s;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = f_in[1];
    v = f_in[0];
    r = '0;
    if (op == 3'd0) begin
      r = a + b;
      c = (longint'(a) + longint'(b)) > 64'sd4294967295;
      s = sa + sb;
      v = s > 64'sd2147483647 || s < -64'sd2147483648;
    end else if (op == 3'd1 || op == 3'd6) begin
      r = a - b;
      c = a >= b;
      s = sa - sb;
      v = s > 64'sd2147483647 || s < -64'sd2147483648;
    end else if (op == 3'd2) r = a & b;
    else if (op == 3'd3) r = a | b;
    else if (op == 3'd4) r = a ^ b;
    else if (op == 3'd5) r = b;
    f = {r[31], r == 32'd0, c, v};
  endfunction

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    m[a] = d;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    logic [31:0] er;
    logic [3:0] ef;
    model(op, m[rs1], m[rs2], mflags, er, ef);
    opcode = op;
    rd_addr = rd;
    rs1_addr = rs1;
    rs2_addr = rs2;
    op_valid = 1'b1;
    chk("ready_idle", op_ready, 1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("src1_read", src1_addr, rs1);
    chk("src2_read", src2_addr, rs2);
    chk("wr_en_read", wr_en, 0);
    @(posedge clk);
    #1;
    chk("src1_exec", src1_addr, 0);
    chk("done_exec", done, 0);
    chk("ready_exec", op_ready, 0);
    @(posedge clk);
    #1;
    chk("wr_en_write", wr_en, op != 3'd6);
    chk("done_write", done, 1);
    chk("dest_write", dest_addr, rd);
    chk("wr_data", wr_data, er);
    chk("flags_before", flags, mflags);
    @(posedge clk);
    #1;
    chk("flags_after", flags, ef);
    chk("done_idle", done, 0);
    chk("wr_en_idle", wr_en, 0);
    chk("ready_after", op_ready, 1);
    if (op != 3'd6) m[rd] = er;
    mflags = ef;
    chk("rf_dest", rf[rd], m[rd]);
  endtask

  initial begin
    int acc[$];
    logic [31:0] exp_w, r;
    logic [3:0] f;
    #3;
    chk("rst_ready", op_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_src1", src1_addr, 0);
    chk("rst_dest", dest_addr, 0);
    chk("rst_wdata", wr_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) load(4'(i), $urandom);
    load(1, 5); load(2, 7);
    do_op(3'd0, 3, 1, 2);
    chk("add_result", rf[3], 12);
    chk("add_flags", flags, 4'b0000);
    load(1, 3); load(2, 5);
    do_op(3'd1, 4, 1, 2);
    chk("sub_flags", flags, 4'b1000);
    load(1, 32'h7FFF_FFFF); load(2, 1);
    do_op(3'd0, 3, 1, 2);
    chk("ovf_flags", flags, 4'b1001);
    do_op(3'd2, 5, 3, 3);
    chk("and_keeps_cv", flags, 4'b1001);
    load(5, 32'h1234); load(6, 32'h1234);
    do_op(3'd6, 7, 5, 6);
    chk("cmp_flags", flags, 4'b0110);
    // Reset in EXEC must abort the op without writing rd.
    load(1, 1); load(2, 2);
    opcode = 3'd0; rd_addr = 9; rs1_addr = 1; rs2_addr = 2; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", op_ready, 1);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_flags", flags, 0);
    chk("arst_wdata", wr_data, 0);
    chk("arst_dest", dest_addr, 0);
    @(posedge clk);
    #1;
    chk("arst_wr_en_edge", wr_en, 0);
    chk("arst_rf_kept", rf[9], m[9]);
    rst_n = 1'b1;
    mflags = '0;
    do_op(3'd0, 9, 1, 2);
    // Held op_valid: three dependent R1=R1+R1 ops accepted every 4 cycles.
    load(1, 1);
    opcode = 3'd0; rd_addr = 1; rs1_addr = 1; rs2_addr = 1; op_valid = 1'b1;
    exp_w = 2;
    for (int k = 0; k < 16; k++) begin
      if (op_ready && op_valid) acc.push_back(k);
      if (wr_en) begin
        chk("b2b_wdata", wr_data, exp_w);
        exp_w = exp_w * 2;
      end
      @(posedge clk);
      #1;
      if (acc.size() == 3) op_valid = 1'b0;
    end
    chk("b2b_count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 4);
      chk("b2b_gap2", acc[2] - acc[1], 4);
    end
    for (int i = 0; i < 3; i++) begin
      model(3'd0, m[1], m[1], mflags, r, f);
      m[1] = r;
      mflags = f;
    end
    chk("b2b_r1", rf[1], 8);
    chk("b2b_flags", flags, mflags);
    for (int i = 0; i < 24; i++)
      do_op(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 16; i++) chk("rf_final", rf[i], m[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
